hovalaag_out_capture: RTL

- Downstream consumer of the Hovalaag CPU output port (OUT, OUT_valid, OUT_select).
- Records every value the CPU writes to OUT1 and OUT2 into two per-channel history buffers, replacing the single last-value registers.
- Exposes a button-driven viewing cursor so the 7-segment display can step through the captured history of the selected channel.
- Runs on the board clock; the CPU's slow-clock output timing is qualified by a one-cycle strobe.

---
 rtl/hovalaag_out_capture_if.sv | 13 +
 rtl/hovalaag_out_capture.sv | 118 +++++++++++
 2 files changed

// File: rtl/hovalaag_out_capture_if.sv
// Hovalaag CPU output port as seen by a downstream consumer; the CPU drives it as master.
// out_strobe marks the one board clock per CPU cycle in which out_valid/out_data may be captured.
interface hovalaag_out_capture_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_select;
  logic              out_strobe;

  modport master (output out_data, output out_valid, output out_select, output out_strobe);
  modport slave  (input  out_data, input  out_valid, input  out_select, input  out_strobe);
endinterface

// File: rtl/hovalaag_out_capture.sv
// Per-channel capture history of the Hovalaag OUT port with a button-driven view cursor; view_data is registered (1 clk), no backpressure.
// Define OUT_CAPTURE_WRAP_EN to overwrite the oldest entry on a full channel instead of dropping the write.
module hovalaag_out_capture #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  hovalaag_out_capture_if.slave cpu,
  input  logic                  view_sel,
  input  logic                  btn_next,
  input  logic                  follow,
  output logic [DATA_W-1:0]     view_data,
  output logic [DEPTH_LOG2-1:0] view_index,
  output logic [DEPTH_LOG2:0]   view_count,
  output logic                  view_empty,
  output logic [1:0]            overflow,
  output logic                  new_entry
);

`ifdef OUT_CAPTURE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  logic [DATA_W-1:0] mem [2][DEPTH];

  ptr_t       wr_ptr     [2];
  cnt_t       count      [2];
  ptr_t       cursor     [2];
  cnt_t       count_nxt  [2];
  ptr_t       cursor_nxt [2];
  logic [1:0] overflow_q;
  logic       btn_q;

  logic       capture;
  logic       btn_edge;
  logic [1:0] cap_ch;
  logic [1:0] full;
  logic [1:0] write_en;
  logic [1:0] wrapped;
  ptr_t       rd_addr;

  assign capture  = cpu.out_strobe & cpu.out_valid;
  assign btn_edge = btn_next & ~btn_q;

  always_comb begin
    cap_ch   = '0;
    full     = '0;
    write_en = '0;
    wrapped  = '0;
    for (int c = 0; c < 2; c++) begin
      count_nxt[c]  = count[c];
      cursor_nxt[c] = cursor[c];
      full[c]       = count[c][DEPTH_LOG2];
      cap_ch[c]     = capture && (cpu.out_select == c[0]);
      write_en[c]   = cap_ch[c] && (!full[c] || WRAP_EN);
      wrapped[c]    = cap_ch[c] && full[c] && WRAP_EN;
      if (write_en[c] && !full[c])
        count_nxt[c] = count[c] + cnt_t'(1);
      // Cursor wrap uses the pre-capture count; follow tracks the post-capture newest entry.
      if (view_sel == c[0]) begin
        if (follow)
          cursor_nxt[c] = (count_nxt[c] == '0) ? '0 : ptr_t'(count_nxt[c] - cnt_t'(1));
        else if (btn_edge && count[c] != '0)
          cursor_nxt[c] = (cnt_t'(cursor[c]) == count[c] - cnt_t'(1)) ? '0 : cursor[c] + ptr_t'(1);
      end
      // Overwriting the oldest entry shifts every relative index down by one.
      if (wrapped[c] && !(follow && view_sel == c[0]) && cursor_nxt[c] != '0)
        cursor_nxt[c] = cursor_nxt[c] - ptr_t'(1);
    end
  end

  // Oldest entry sits count slots behind the write pointer; a full count truncates to 0.
  assign rd_addr = wr_ptr[view_sel] - ptr_t'(count[view_sel]) + cursor[view_sel];

  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++)
      if (write_en[c])
        mem[c][wr_ptr[c]] <= cpu.out_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr[c] <= '0;
        count[c]  <= '0;
        cursor[c] <= '0;
      end
      overflow_q <= '0;
      new_entry  <= 1'b0;
      view_data  <= '0;
      btn_q      <= btn_next;
    end else begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr[c]     <= wr_ptr[c] + ptr_t'(write_en[c]);
        count[c]      <= count_nxt[c];
        cursor[c]     <= cursor_nxt[c];
        overflow_q[c] <= overflow_q[c] | (cap_ch[c] & full[c]);
      end
      new_entry <= write_en[view_sel];
      btn_q     <= btn_next;
      view_data <= (count[view_sel] == '0) ? '0 : mem[view_sel][rd_addr];
    end
  end

  assign view_index = cursor[view_sel];
  assign view_count = count[view_sel];
  assign view_empty = (count[view_sel] == '0);
  assign overflow   = overflow_q;

endmodule
